// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CH phase-accumulator clock-enable generators behind a settle/lock sequencer.
// Defining CLKGEN_SQUARE_OUT_EN adds the clk_sq divided square-wave outputs.
module clk_enable_gen #(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 32,
  parameter int LOCK_DELAY = 1024
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic                    load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ce_out,
`ifdef CLKGEN_SQUARE_OUT_EN
  output logic [NUM_CH-1:0]       clk_sq,
`endif
  output logic                    locked
);

  localparam int                 CNT_W     = 16;
  localparam logic [0:0]         ST_SETTLE = 1'b0;
  localparam logic [0:0]         ST_LOCKED = 1'b1;
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_DELAY - 1);

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic [NUM_CH*ACC_W-1:0] inc_reg_q, inc_reg_d;
  logic [NUM_CH-1:0]       en_reg_q, en_reg_d;
  logic [NUM_CH-1:0]       ce_q, ce_d;
  logic [ACC_W-1:0]        acc_q [NUM_CH];
  logic [ACC_W-1:0]        acc_d [NUM_CH];
  logic [ACC_W:0]          sum   [NUM_CH];

  // The extra top bit of each sum is the wrap carry that becomes the enable pulse.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_reg_q[i*ACC_W +: ACC_W]};
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    inc_reg_d  = inc_reg_q;
    en_reg_d   = en_reg_q;
    ce_d       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i] = '0;
    end

    if (load) begin
      state_d    = ST_SETTLE;
      lock_cnt_d = '0;
      inc_reg_d  = inc;
      en_reg_d   = ch_en;
    end else if (state_q == ST_SETTLE) begin
      if (lock_cnt_q == LOCK_LAST) begin
        state_d    = ST_LOCKED;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en_reg_q[i]) begin
          acc_d[i] = sum[i][ACC_W-1:0];
          ce_d[i]  = sum[i][ACC_W];
        end
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SETTLE;
      lock_cnt_q <= '0;
      inc_reg_q  <= '0;
      en_reg_q   <= '0;
      ce_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      inc_reg_q  <= inc_reg_d;
      en_reg_q   <= en_reg_d;
      ce_q       <= ce_d;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign ce_out = ce_q;
  assign locked = (state_q == ST_LOCKED);

`ifdef CLKGEN_SQUARE_OUT_EN
  logic [NUM_CH-1:0] clk_sq_q, clk_sq_d;

  // Tracks the accumulator MSB of the same cycle, so it is zero whenever acc is held at zero.
  always_comb begin
    clk_sq_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clk_sq_d[i] = acc_d[i][ACC_W-1];
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      clk_sq_q <= '0;
    end else begin
      clk_sq_q <= clk_sq_d;
    end
  end

  assign clk_sq = clk_sq_q;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: closed-form rate model compared every cycle, plus hand-computed scenarios.
module tb_clk_enable_gen;
  localparam int NUM_CH = 4;
  localparam int ACC_W  = 8;
  localparam int LD     = 16;

  logic                    refclk = 1'b0;
  logic                    rst    = 1'b1;
  logic                    load   = 1'b0;
  logic [NUM_CH*ACC_W-1:0] inc    = '0;
  logic [NUM_CH-1:0]       ch_en  = '0;
  logic [NUM_CH-1:0]       ce_out;
  logic                    locked;
`ifdef CLKGEN_SQUARE_OUT_EN
  logic [NUM_CH-1:0]       clk_sq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  clk_enable_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_DELAY(LD)) dut (
    .refclk (refclk),
    .rst    (rst),
    .inc    (inc),
    .load   (load),
    .ch_en  (ch_en),
    .ce_out (ce_out),
`ifdef CLKGEN_SQUARE_OUT_EN
    .clk_sq (clk_sq),
`endif
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: only counts edges since the last load/reset and the captured settings.
  longint          m_k = 0;
  logic [ACC_W-1:0] m_inc [NUM_CH] = '{default: '0};
  logic [NUM_CH-1:0] m_en = '0;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_k  <= 0;
      m_en <= '0;
      for (int i = 0; i < NUM_CH; i++) m_inc[i] <= '0;
    end else if (load) begin
      m_k  <= 0;
      m_en <= ch_en;
      for (int i = 0; i < NUM_CH; i++) m_inc[i] <= inc[i*ACC_W +: ACC_W];
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic logic model_locked();
    return m_k >= LD;
  endfunction

  // After n accumulations the phase is n*inc; a pulse marks each new multiple of 2^ACC_W crossed.
  function automatic logic [NUM_CH-1:0] model_ce();
    logic [NUM_CH-1:0] r = '0;
    longint n = m_k - LD;
    for (int i = 0; i < NUM_CH; i++) begin
      longint v = longint'(m_inc[i]);
      if (m_en[i] && n >= 1 && ((n * v) >> ACC_W) != (((n - 1) * v) >> ACC_W)) r[i] = 1'b1;
    end
    return r;
  endfunction

`ifdef CLKGEN_SQUARE_OUT_EN
  function automatic logic [NUM_CH-1:0] model_sq();
    logic [NUM_CH-1:0] r = '0;
    longint n = m_k - LD;
    for (int i = 0; i < NUM_CH; i++) begin
      longint v = longint'(m_inc[i]);
      if (m_en[i] && n >= 1 && (((n * v) >> (ACC_W - 1)) % 2) != 0) r[i] = 1'b1;
    end
    return r;
  endfunction
`endif

  always @(negedge refclk) begin
    check("model_ce_out", 64'(ce_out), 64'(model_ce()));
    check("model_locked", 64'(locked), 64'(model_locked()));
`ifdef CLKGEN_SQUARE_OUT_EN
    check("model_clk_sq", 64'(clk_sq), 64'(model_sq()));
`endif
  end

  function automatic logic [NUM_CH*ACC_W-1:0] pack4(input logic [ACC_W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Returns 1 time unit after the load edge.
  task automatic do_load(input logic [NUM_CH*ACC_W-1:0] v, input logic [NUM_CH-1:0] e);
    @(posedge refclk);
    #1;
    inc   = v;
    ch_en = e;
    load  = 1'b1;
    @(posedge refclk);
    #1;
    load  = 1'b0;
  endtask

  initial begin
    // Reset state held over several edges
    repeat (2) @(posedge refclk);
    #1;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_ce_out", 64'(ce_out), 64'd0);
    #1;
    rst = 1'b0;

    // Lock timing after reset release; en_reg is zero so no pulses
    for (int e = 1; e <= LD; e++) begin
      @(posedge refclk);
      #1;
      if (e == LD - 1) check("lock_edge15", 64'(locked), 64'd0);
      if (e == LD)     check("lock_edge16", 64'(locked), 64'd1);
      check("ce_idle_after_rst", 64'(ce_out), 64'd0);
    end

    // inc/ch_en changes without load have no effect
    inc   = pack4(8'd128, 8'd1, 8'd2, 8'd3);
    ch_en = 4'b1111;
    repeat (6) @(posedge refclk);
    #1;
    check("no_load_no_effect", 64'(ce_out), 64'd0);

    // ch0 inc=64: pulses after L+4, L+8, L+12
    do_load(pack4(8'd64, 8'd0, 8'd0, 8'd0), 4'b0001);
    check("load_drops_lock", 64'(locked), 64'd0);
    repeat (LD) @(posedge refclk);
    #1;
    check("lock_after_load", 64'(locked), 64'd1);
    for (int j = 1; j <= 12; j++) begin
      @(posedge refclk);
      #1;
      check("inc64_pattern", 64'(ce_out), (j % 4 == 0) ? 64'd1 : 64'd0);
      if (j == 6) begin
        inc   = pack4(8'd255, 8'd255, 8'd255, 8'd255);
        ch_en = 4'b1111;
      end
    end

    // ch1 inc=255, ch2 inc=0, ch3 disabled
    do_load(pack4(8'd0, 8'd255, 8'd0, 8'd77), 4'b0110);
    repeat (LD) @(posedge refclk);
    for (int j = 1; j <= 6; j++) begin
      @(posedge refclk);
      #1;
      check("inc255_inc0", 64'(ce_out), (j == 1) ? 64'd0 : 64'd2);
    end

    // Reload while LOCKED with ch0 inc=128
    do_load(pack4(8'd128, 8'd0, 8'd0, 8'd0), 4'b0001);
    check("reload_locked_fall", 64'(locked), 64'd0);
    check("reload_ce_cleared", 64'(ce_out), 64'd0);
    for (int e = 1; e <= LD; e++) begin
      @(posedge refclk);
      #1;
      check("reload_settle_ce", 64'(ce_out), 64'd0);
      if (e == LD - 1) check("reload_settle_lock", 64'(locked), 64'd0);
    end
    check("reload_relock", 64'(locked), 64'd1);
    for (int j = 1; j <= 4; j++) begin
      @(posedge refclk);
      #1;
      check("inc128_pattern", 64'(ce_out), (j % 2 == 0) ? 64'd1 : 64'd0);
    end

    // 1 ns reset pulse during a pulse: outputs drop with no clock edge
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_ce", 64'(ce_out), 64'd0);
    check("async_rst_locked", 64'(locked), 64'd0);
    rst = 1'b0;
    repeat (LD + 8) @(posedge refclk);
    #1;
    check("post_rst_locked", 64'(locked), 64'd1);
    check("post_rst_silent", 64'(ce_out), 64'd0);

`ifdef CLKGEN_SQUARE_OUT_EN
    // inc=32: 8-cycle period, low 4 / high 4
    do_load(pack4(8'd32, 8'd0, 8'd0, 8'd0), 4'b0001);
    check("sq_settle_zero", 64'(clk_sq), 64'd0);
    repeat (LD) @(posedge refclk);
    for (int j = 1; j <= 16; j++) begin
      @(posedge refclk);
      #1;
      check("sq_period8", 64'(clk_sq[0]), ((j % 8) >= 4) ? 64'd1 : 64'd0);
    end
`endif

    repeat (2) @(posedge refclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
